// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
//   in_valid/in_data : producer offers a word; in_ready : serializer can accept it
//   ser_out/ser_valid: serial bit stream; word_done marks a word's last bit
//   busy             : serializer still has work queued or in flight
// master: the word producer / serial consumer side. slave: the serializer.
interface bit_serializer_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         ser_out;
  logic         ser_valid;
  logic         word_done;
  logic         busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, ser_valid, word_done, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, ser_valid, word_done, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: words enter a small FIFO over valid/ready and are shifted out one
// bit per clock, optionally separated by GAP idle cycles.
//   clk : single clock, posedge
//   rst : synchronous, active-high reset (drops FIFO contents and any word in flight)
//   bus : bit_serializer_if slave modport (in_valid/in_ready/in_data in,
//         ser_out/ser_valid/word_done/busy out; serial outputs are registered)
module bit_serializer #(
  parameter int unsigned W         = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned GAP       = 0,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  bit_serializer_if.slave   bus
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned BCW = $clog2(W);
  // Keep at least one bit so GAP=0 still elaborates a legal vector.
  localparam int unsigned GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BCW-1:0] BitLast = BCW'(W - 1);
  localparam logic [GCW-1:0] GapLast = GCW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  // FIFO: pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, rd_ptr_q;
  logic         full, empty, push, pop;
  logic [W-1:0] rd_data;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push    = bus.in_valid && !full;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Shifter FSM
  state_e         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
  logic           last_bit, cur_bit;

  assign cur_bit = MSB_FIRST ? shift_q[W-1] : shift_q[0];

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pop       = 1'b0;
    last_bit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
        if (bit_cnt_q == BitLast) begin
          last_bit = 1'b1;
          if (GAP > 0) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else if (!empty) begin
            pop = 1'b1;  // next word follows with no bubble
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GapLast) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = StShift;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      shift_d   = rd_data;
      bit_cnt_d = '0;
    end
  end

  // Serial outputs are registered, so the bit the FSM holds now appears one cycle later.
  logic ser_out_q, ser_valid_q, word_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_out_q   <= (state_q == StShift) && cur_bit;
      ser_valid_q <= (state_q == StShift);
      word_done_q <= last_bit;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.word_done = word_done_q;
  assign bus.busy      = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (MSB-first/GAP=0, MSB-first/GAP=3, LSB-first/GAP=0)
// driven from a vector table plus hand-written multi-cycle sequences.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_serializer_if #(.W(8)) if0 ();
  bit_serializer_if #(.W(8)) if1 ();
  bit_serializer_if #(.W(8)) if2 ();

  bit_serializer #(.W(8), .DEPTH(4), .GAP(0), .MSB_FIRST(1'b1)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );
  bit_serializer #(.W(8), .DEPTH(4), .GAP(3), .MSB_FIRST(1'b1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );
  bit_serializer #(.W(8), .DEPTH(4), .GAP(0), .MSB_FIRST(1'b0)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  logic s_out [3];
  logic s_valid [3];
  logic s_done [3];
  logic s_busy [3];
  logic s_ready [3];
  assign s_out[0] = if0.ser_out;    assign s_out[1] = if1.ser_out;    assign s_out[2] = if2.ser_out;
  assign s_valid[0] = if0.ser_valid; assign s_valid[1] = if1.ser_valid;
  assign s_valid[2] = if2.ser_valid;
  assign s_done[0] = if0.word_done; assign s_done[1] = if1.word_done;
  assign s_done[2] = if2.word_done;
  assign s_busy[0] = if0.busy;      assign s_busy[1] = if1.busy;      assign s_busy[2] = if2.busy;
  assign s_ready[0] = if0.in_ready; assign s_ready[1] = if1.in_ready;
  assign s_ready[2] = if2.in_ready;

  int tests = 0;
  int fails = 0;

  // Reassemble words from instance 0 (MSB first) for ordering/loss checks.
  logic [7:0] col_sr = '0;
  logic [7:0] col_q [$];
  always @(negedge clk) begin
    if (!rst && s_valid[0]) begin
      col_sr <= {col_sr[6:0], s_out[0]};
      if (s_done[0]) col_q.push_back({col_sr[6:0], s_out[0]});
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    case (sel)
      0: begin if0.in_valid = v; if0.in_data = d; end
      1: begin if1.in_valid = v; if1.in_data = d; end
      default: begin if2.in_valid = v; if2.in_data = d; end
    endcase
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [7:0] exp;   // exp[7] is the first bit expected on ser_out
    string      name;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    @(negedge clk); drive(v.sel, 1'b1, v.data);
    @(posedge clk); #1; drive(v.sel, 1'b0, 8'h00);
    @(posedge clk); #1; check({v.name, " latency"}, 32'(s_valid[v.sel]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s valid[%0d]", v.name, i), 32'(s_valid[v.sel]), 32'd1);
      check($sformatf("%s bit[%0d]", v.name, i), 32'(s_out[v.sel]), 32'(v.exp[7-i]));
      check($sformatf("%s done[%0d]", v.name, i), 32'(s_done[v.sel]), 32'(i == 7));
    end
    @(posedge clk); #1;
    check({v.name, " after valid"}, 32'(s_valid[v.sel]), 32'd0);
    check({v.name, " after out"}, 32'(s_out[v.sel]), 32'd0);
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int cyc;
    int stray;
    logic exp_b;

    vecs[0] = '{sel: 0, data: 8'hA5, exp: 8'b1010_0101, name: "msb A5"};
    vecs[1] = '{sel: 0, data: 8'h3C, exp: 8'b0011_1100, name: "msb 3C"};
    vecs[2] = '{sel: 2, data: 8'h01, exp: 8'b1000_0000, name: "lsb 01"};
    vecs[3] = '{sel: 2, data: 8'h0F, exp: 8'b1111_0000, name: "lsb 0F"};
    vecs[4] = '{sel: 2, data: 8'hC8, exp: 8'b0001_0011, name: "lsb C8"};
    vecs[5] = '{sel: 1, data: 8'h81, exp: 8'b1000_0001, name: "gap 81"};

    for (int s = 0; s < 3; s++) drive(s, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;

    // Reset state
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst out%0d", s), 32'(s_out[s]), 32'd0);
      check($sformatf("rst valid%0d", s), 32'(s_valid[s]), 32'd0);
      check($sformatf("rst done%0d", s), 32'(s_done[s]), 32'd0);
      check($sformatf("rst busy%0d", s), 32'(s_busy[s]), 32'd0);
      check($sformatf("rst ready%0d", s), 32'(s_ready[s]), 32'd1);
    end

    foreach (vecs[k]) run_vec(vecs[k]);

    // Back-to-back FF then 00 with no gap
    @(negedge clk); drive(0, 1'b1, 8'hFF);
    @(posedge clk); #1; drive(0, 1'b1, 8'h00);
    @(posedge clk); #1; drive(0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b valid[%0d]", i), 32'(s_valid[0]), 32'd1);
      check($sformatf("b2b bit[%0d]", i), 32'(s_out[0]), 32'(i < 8));
      check($sformatf("b2b done[%0d]", i), 32'(s_done[0]), 32'(i == 7 || i == 15));
    end
    @(posedge clk); #1; check("b2b tail valid", 32'(s_valid[0]), 32'd0);
    repeat (4) @(posedge clk);

    // GAP=3: two 81 words separated by three idle cycles
    @(negedge clk); drive(1, 1'b1, 8'h81);
    @(posedge clk); #1; drive(1, 1'b1, 8'h81);
    @(posedge clk); #1; drive(1, 1'b0, 8'h00);
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      if (i >= 8 && i <= 10) begin
        check($sformatf("gap idle valid[%0d]", i), 32'(s_valid[1]), 32'd0);
        check($sformatf("gap idle out[%0d]", i), 32'(s_out[1]), 32'd0);
      end else begin
        exp_b = (i == 0 || i == 7 || i == 11 || i == 18);
        check($sformatf("gap valid[%0d]", i), 32'(s_valid[1]), 32'd1);
        check($sformatf("gap bit[%0d]", i), 32'(s_out[1]), 32'(exp_b));
        check($sformatf("gap done[%0d]", i), 32'(s_done[1]), 32'(i == 7 || i == 18));
      end
    end
    repeat (6) @(posedge clk);

    // Hold in_valid for DEPTH+2 cycles with the shifter stalled on its first word
    col_q.delete();
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(0, 1'b1, 8'(8'h11 + acc));
      check($sformatf("fill ready[%0d]", c), 32'(s_ready[0]), 32'(c < 5));
      if (s_ready[0]) acc++;
    end
    @(posedge clk); #1; drive(0, 1'b0, 8'h00);
    check("fill accepted", 32'(acc), 32'd5);
    cyc = 0;
    while ((col_q.size() < 5 || s_busy[0]) && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check("fill drain timeout", 32'(cyc < 200), 32'd1);
    check("fill word count", 32'(col_q.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < col_q.size()) check($sformatf("fill word[%0d]", k), 32'(col_q[k]), 32'(8'h11 + k));
    end
    repeat (4) @(posedge clk);

    // Reset during bit 3 of the first of three queued words
    col_q.delete();
    @(negedge clk); drive(0, 1'b1, 8'hA1);
    @(posedge clk); #1; drive(0, 1'b1, 8'hB2);
    @(posedge clk); #1; drive(0, 1'b1, 8'hC3);
    @(posedge clk); #1; drive(0, 1'b0, 8'h00);
    repeat (3) begin @(posedge clk); #1; end
    check("mid valid bit3", 32'(s_valid[0]), 32'd1);
    check("mid out bit3", 32'(s_out[0]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid rst valid", 32'(s_valid[0]), 32'd0);
    check("mid rst out", 32'(s_out[0]), 32'd0);
    check("mid rst done", 32'(s_done[0]), 32'd0);
    check("mid rst busy", 32'(s_busy[0]), 32'd0);
    check("mid rst ready", 32'(s_ready[0]), 32'd1);
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (s_valid[0] || s_out[0] || s_busy[0]) stray++;
    end
    check("mid rst stray cycles", 32'(stray), 32'd0);
    check("mid rst words out", 32'(col_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
